// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul engine: FSM states, control-word
// field positions, dimension clamping and flat-image slice indexing.
package matmul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_N_LSB     = 8;
   localparam int CTRL_N_MSB     = 9;
   localparam int CTRL_K_LSB     = 10;
   localparam int CTRL_K_MSB     = 11;
   localparam int CTRL_M_LSB     = 12;
   localparam int CTRL_M_MSB     = 13;

   // Encoded field is (dim - 1); clamp it to the engine size, return the real dimension.
   function automatic logic [2:0] clamp_dim(input logic [1:0] field, input int max_dim);
      int f;
      f = int'(field);
      if (f > max_dim - 1) f = max_dim - 1;
      return 3'(f + 1);
   endfunction

   function automatic int a_slice(input int i, input int k, input int max_dim);
      return max_dim * i + k;
   endfunction

   // B is stored column-major.
   function automatic int b_slice(input int j, input int k, input int max_dim);
      return max_dim * j + k;
   endfunction

   function automatic int c_slice(input int i, input int j, input int max_dim);
      return max_dim * i + j;
   endfunction

endpackage

// File: rtl/matmul_pe.sv
// One result element: signed multiply-accumulate register with a sticky
// signed-overflow flag, cleared at operation accept.
module matmul_pe
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BUS_WIDTH  = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         enable,
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   output logic signed [BUS_WIDTH-1:0]  acc,
   output logic                         flag
);

   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [BUS_WIDTH-1:0]    prod_ext;
   logic signed [BUS_WIDTH-1:0]    sum;

   function automatic logic add_ovf(input logic signed [BUS_WIDTH-1:0] x,
                                    input logic signed [BUS_WIDTH-1:0] y,
                                    input logic signed [BUS_WIDTH-1:0] s);
      return (x[BUS_WIDTH-1] == y[BUS_WIDTH-1]) && (s[BUS_WIDTH-1] != x[BUS_WIDTH-1]);
   endfunction

   // Full-width product cannot overflow; only the accumulate can wrap.
   assign prod     = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
   assign prod_ext = BUS_WIDTH'(prod);
   assign sum      = acc + prod_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc  <= '0;
         flag <= 1'b0;
      end else if (clear) begin
         acc  <= '0;
         flag <= 1'b0;
      end else if (enable) begin
         acc  <= sum;
         flag <= flag | add_ovf(acc, prod_ext, sum);
      end
   end

endmodule

// File: rtl/matmul_engine.sv
// Sequential signed matrix multiply: latches A/B and dims on start, adds one
// outer product per cycle into a MAX_DIM x MAX_DIM PE array, pulses done_o.
module matmul_engine
   import matmul_pkg::*;
#(
   parameter  int DATA_WIDTH = 8,
   parameter  int BUS_WIDTH  = 32,
   localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
   localparam int OPW        = MAX_DIM * MAX_DIM * DATA_WIDTH,
   localparam int RESW       = MAX_DIM * MAX_DIM * BUS_WIDTH
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       start_i,
   input  logic [1:0]                 dim_n_i,
   input  logic [1:0]                 dim_k_i,
   input  logic [1:0]                 dim_m_i,
   input  logic [OPW-1:0]             a_row_i,
   input  logic [OPW-1:0]             b_col_i,
   output logic [RESW-1:0]            fin_r_o,
   output logic [MAX_DIM*MAX_DIM-1:0] ouflow_o,
   output logic                       done_o,
   output logic                       busy_o
);

   state_t         state, state_next;
   logic [1:0]     k;
   logic [2:0]     nd, kd, md;
   logic [OPW-1:0] a_lat, b_lat;
   logic           accept;
   logic           last_k;
   logic           mac_en;

   assign accept = (state == IDLE) && start_i;
   assign last_k = ({1'b0, k} == (kd - 3'd1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         k     <= 2'd0;
         nd    <= 3'd1;
         kd    <= 3'd1;
         md    <= 3'd1;
      end else begin
         state <= state_next;
         if (accept) begin
            k  <= 2'd0;
            nd <= clamp_dim(dim_n_i, MAX_DIM);
            kd <= clamp_dim(dim_k_i, MAX_DIM);
            md <= clamp_dim(dim_m_i, MAX_DIM);
         end else if (state == MAC) begin
            k <= k + 2'd1;
         end
      end
   end

   // Operand images are pure data; they only matter once an accept has loaded them.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         a_lat <= a_row_i;
         b_lat <= b_col_i;
      end
   end

   always_comb begin
      state_next = state;
      mac_en     = 1'b0;
      unique case (state)
         IDLE: if (start_i) state_next = MAC;
         MAC: begin
            mac_en = 1'b1;
            if (last_k) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign done_o = (state == DONE);
   assign busy_o = (state != IDLE);

   // Column k of A and row k of B feed the array; out-of-range elements stay idle.
   for (genvar i = 0; i < MAX_DIM; i++) begin : g_row
      for (genvar j = 0; j < MAX_DIM; j++) begin : g_col
         logic pe_en;
         assign pe_en = mac_en && (3'(i) < nd) && (3'(j) < md);

         matmul_pe #(
            .DATA_WIDTH (DATA_WIDTH),
            .BUS_WIDTH  (BUS_WIDTH)
         ) u_pe (
            .clk    (clk_i),
            .rst_n  (rst_ni),
            .clear  (accept),
            .enable (pe_en),
            .a      (a_lat[DATA_WIDTH*a_slice(i, int'(k), MAX_DIM) +: DATA_WIDTH]),
            .b      (b_lat[DATA_WIDTH*b_slice(j, int'(k), MAX_DIM) +: DATA_WIDTH]),
            .acc    (fin_r_o[BUS_WIDTH*c_slice(i, j, MAX_DIM) +: BUS_WIDTH]),
            .flag   (ouflow_o[c_slice(i, j, MAX_DIM)])
         );
      end
   end

endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine: an 8/32 instance (4x4) and a 16/32
// instance (2x2) for the accumulate-overflow case.
module tb_matmul_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic         start8, done8, busy8;
   logic [1:0]   dn8, dk8, dm8;
   logic [127:0] a8, b8;
   logic [511:0] c8;
   logic [15:0]  of8;

   logic         start16, done16, busy16;
   logic [1:0]   dn16, dk16, dm16;
   logic [63:0]  a16, b16;
   logic [127:0] c16;
   logic [3:0]   of16;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  am [4][4];
   logic [7:0]  bm [4][4];
   logic [31:0] exp_c [4][4];

   matmul_engine #(.DATA_WIDTH(8), .BUS_WIDTH(32)) u_dut8 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start8),
      .dim_n_i(dn8), .dim_k_i(dk8), .dim_m_i(dm8),
      .a_row_i(a8), .b_col_i(b8), .fin_r_o(c8), .ouflow_o(of8),
      .done_o(done8), .busy_o(busy8)
   );

   matmul_engine #(.DATA_WIDTH(16), .BUS_WIDTH(32)) u_dut16 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start16),
      .dim_n_i(dn16), .dim_k_i(dk16), .dim_m_i(dm16),
      .a_row_i(a16), .b_col_i(b16), .fin_r_o(c16), .ouflow_o(of16),
      .done_o(done16), .busy_o(busy16)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mats();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            am[i][j]    = 8'h00;
            bm[i][j]    = 8'h00;
            exp_c[i][j] = 32'h0;
         end
   endtask

   task automatic pack8();
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++) begin
            a8[8*(4*i+k) +: 8] = am[i][k];
            b8[8*(4*i+k) +: 8] = bm[k][i];
         end
   endtask

   task automatic pulse8(input logic [1:0] n, input logic [1:0] k, input logic [1:0] m);
      dn8 = n; dk8 = k; dm8 = m;
      start8 = 1'b1;
      step();
      start8 = 1'b0;
   endtask

   task automatic wait_done8(output int lat);
      lat = 0;
      while (!done8 && lat < 20) begin
         step();
         lat++;
      end
   endtask

   task automatic wait_done16(output int lat);
      lat = 0;
      while (!done16 && lat < 20) begin
         step();
         lat++;
      end
   endtask

   task automatic load_rect();
      clear_mats();
      am[0][0] = 8'd1; am[0][1] = 8'd2;  am[0][2] = 8'd3;
      am[1][0] = 8'd4; am[1][1] = 8'd5;  am[1][2] = 8'd6;
      bm[0][0] = 8'd7; bm[0][1] = 8'd8;
      bm[1][0] = 8'd9; bm[1][1] = 8'd10;
      bm[2][0] = 8'd11; bm[2][1] = 8'd12;
      // Elements outside the 2x3 * 3x2 window must not leak into the result.
      am[0][3] = 8'd9; am[2][0] = 8'd3; bm[0][2] = 8'd4; bm[3][3] = 8'd7;
      exp_c[0][0] = 32'd58;  exp_c[0][1] = 32'd64;
      exp_c[1][0] = 32'd139; exp_c[1][1] = 32'd154;
      pack8();
   endtask

   task automatic test_reset();
      step();
      step();
      n_cmp++; if (c8 !== '0)     begin n_bad++; $display("FAIL reset_fin8: got %h want 0", c8); end
      n_cmp++; if (of8 !== '0)    begin n_bad++; $display("FAIL reset_ouflow8: got %h want 0", of8); end
      n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL reset_done8: got %b want 0", done8); end
      n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL reset_busy8: got %b want 0", busy8); end
      n_cmp++; if (c16 !== '0)    begin n_bad++; $display("FAIL reset_fin16: got %h want 0", c16); end
      n_cmp++; if ({of16, done16, busy16} !== '0) begin
         n_bad++; $display("FAIL reset_ctrl16: got %b want 0", {of16, done16, busy16});
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_identity();
      int lat;
      clear_mats();
      for (int i = 0; i < 4; i++) am[i][i] = 8'd1;
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 4; j++) bm[k][j] = 8'(4*k + j + 1);
      pack8();
      pulse8(2'd3, 2'd3, 2'd3);
      wait_done8(lat);
      n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL ident_latency: got %0d want 4", lat); end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (c8[32*(4*i+j) +: 32] !== 32'(4*i + j + 1)) begin
               n_bad++;
               $display("FAIL ident_c%0d%0d: got %h want %h", i, j, c8[32*(4*i+j) +: 32], 32'(4*i + j + 1));
            end
         end
      n_cmp++; if (of8 !== 16'h0)  begin n_bad++; $display("FAIL ident_ouflow: got %h want 0", of8); end
      n_cmp++; if (busy8 !== 1'b1) begin n_bad++; $display("FAIL ident_busy_at_done: got %b want 1", busy8); end
      step();
      n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL ident_done_width: got %b want 0", done8); end
      n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL ident_busy_after: got %b want 0", busy8); end
      n_cmp++; if (c8[31:0] !== 32'd1) begin n_bad++; $display("FAIL ident_hold: got %h want 1", c8[31:0]); end
   endtask

   task automatic test_rectangular();
      int lat;
      load_rect();
      pulse8(2'd1, 2'd2, 2'd1);
      wait_done8(lat);
      n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL rect_latency: got %0d want 3", lat); end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (c8[32*(4*i+j) +: 32] !== exp_c[i][j]) begin
               n_bad++;
               $display("FAIL rect_c%0d%0d: got %h want %h", i, j, c8[32*(4*i+j) +: 32], exp_c[i][j]);
            end
         end
      n_cmp++; if (of8 !== 16'h0) begin n_bad++; $display("FAIL rect_ouflow: got %h want 0", of8); end
      step();
   endtask

   task automatic test_signed();
      int lat;
      clear_mats();
      am[0][0] = 8'h80; bm[0][0] = 8'h80;
      pack8();
      pulse8(2'd0, 2'd0, 2'd0);
      wait_done8(lat);
      n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL signed_latency: got %0d want 1", lat); end
      n_cmp++; if (c8[31:0] !== 32'h00004000) begin n_bad++; $display("FAIL signed_min_sq: got %h want 00004000", c8[31:0]); end
      n_cmp++; if (c8[511:32] !== '0) begin n_bad++; $display("FAIL signed_others: got nonzero %h", c8[511:32]); end
      n_cmp++; if (of8 !== 16'h0) begin n_bad++; $display("FAIL signed_ouflow1: got %h want 0", of8); end
      step();
      am[0][0] = 8'hFD; bm[0][0] = 8'h05;
      pack8();
      pulse8(2'd0, 2'd0, 2'd0);
      wait_done8(lat);
      n_cmp++; if (c8[31:0] !== 32'hFFFFFFF1) begin n_bad++; $display("FAIL signed_neg: got %h want fffffff1", c8[31:0]); end
      n_cmp++; if (of8 !== 16'h0) begin n_bad++; $display("FAIL signed_ouflow2: got %h want 0", of8); end
      step();
   endtask

   task automatic test_overflow();
      int lat;
      a16 = {32'h0, 16'h8000, 16'h8000};
      b16 = {32'h0, 16'h8000, 16'h8000};
      dn16 = 2'd0; dk16 = 2'd1; dm16 = 2'd0;
      start16 = 1'b1;
      step();
      start16 = 1'b0;
      wait_done16(lat);
      n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL ovf_latency: got %0d want 2", lat); end
      n_cmp++; if (c16[31:0] !== 32'h80000000) begin n_bad++; $display("FAIL ovf_c00: got %h want 80000000", c16[31:0]); end
      n_cmp++; if (of16 !== 4'b0001) begin n_bad++; $display("FAIL ovf_flag: got %b want 0001", of16); end
      n_cmp++; if (c16[127:32] !== '0) begin n_bad++; $display("FAIL ovf_others: got %h want 0", c16[127:32]); end
      step();
      a16 = 64'h1; b16 = 64'h1; dk16 = 2'd0;
      start16 = 1'b1;
      step();
      start16 = 1'b0;
      n_cmp++; if (of16 !== 4'b0000) begin n_bad++; $display("FAIL ovf_clear_on_start: got %b want 0000", of16); end
      wait_done16(lat);
      n_cmp++; if (c16[31:0] !== 32'h1) begin n_bad++; $display("FAIL ovf_next_c00: got %h want 1", c16[31:0]); end
      n_cmp++; if (of16 !== 4'b0000) begin n_bad++; $display("FAIL ovf_next_flag: got %b want 0000", of16); end
      step();
   endtask

   task automatic test_ignore_abort();
      int lat;
      int seen;
      clear_mats();
      for (int i = 0; i < 4; i++) am[i][i] = 8'd2;
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 4; j++) bm[k][j] = 8'(4*k + j + 1);
      pack8();
      pulse8(2'd3, 2'd3, 2'd3);
      step();
      step();
      a8 = {16{8'h7F}}; b8 = {16{8'h7F}};
      dn8 = 2'd0; dk8 = 2'd0; dm8 = 2'd0;
      start8 = 1'b1;
      step();
      start8 = 1'b0;
      wait_done8(lat);
      n_cmp++; if (lat + 3 != 4) begin n_bad++; $display("FAIL ignore_latency: got %0d want 4", lat + 3); end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (c8[32*(4*i+j) +: 32] !== 32'(2*(4*i + j + 1))) begin
               n_bad++;
               $display("FAIL ignore_c%0d%0d: got %h want %h", i, j, c8[32*(4*i+j) +: 32], 32'(2*(4*i + j + 1)));
            end
         end
      step();

      pack8();
      pulse8(2'd3, 2'd3, 2'd3);
      step();
      step();
      rst_n = 1'b0;
      #1;
      n_cmp++; if (c8 !== '0) begin n_bad++; $display("FAIL abort_fin: got %h want 0", c8); end
      n_cmp++; if ({of8, done8, busy8} !== '0) begin
         n_bad++; $display("FAIL abort_ctrl: got %b want 0", {of8, done8, busy8});
      end
      seen = 0;
      start8 = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         if (done8 || busy8) seen++;
      end
      start8 = 1'b0;
      rst_n  = 1'b1;
      step();
      if (done8 || busy8) seen++;
      n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen); end

      load_rect();
      pulse8(2'd1, 2'd2, 2'd1);
      wait_done8(lat);
      n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL restart_latency: got %0d want 3", lat); end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (c8[32*(4*i+j) +: 32] !== exp_c[i][j]) begin
               n_bad++;
               $display("FAIL restart_c%0d%0d: got %h want %h", i, j, c8[32*(4*i+j) +: 32], exp_c[i][j]);
            end
         end
      step();
   endtask

   task automatic test_back_to_back();
      int lat;
      clear_mats();
      am[0][0] = 8'd2; am[0][1] = 8'd3;
      bm[0][0] = 8'd4; bm[1][0] = 8'd5;
      pack8();
      dn8 = 2'd0; dk8 = 2'd1; dm8 = 2'd0;
      start8 = 1'b1;
      step();
      am[0][0] = 8'hFF; am[0][1] = 8'd1;
      bm[0][0] = 8'd7;  bm[1][0] = 8'd2;
      pack8();
      wait_done8(lat);
      n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL b2b_lat1: got %0d want 2", lat); end
      n_cmp++; if (c8[31:0] !== 32'd23) begin n_bad++; $display("FAIL b2b_first: got %h want 00000017", c8[31:0]); end
      step();
      n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL b2b_not_in_done: got busy %b want 0", busy8); end
      n_cmp++; if (c8[31:0] !== 32'd23) begin n_bad++; $display("FAIL b2b_hold: got %h want 00000017", c8[31:0]); end
      step();
      start8 = 1'b0;
      n_cmp++; if (busy8 !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: got busy %b want 1", busy8); end
      n_cmp++; if (c8[31:0] !== 32'd0) begin n_bad++; $display("FAIL b2b_cleared: got %h want 0", c8[31:0]); end
      wait_done8(lat);
      n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL b2b_lat2: got %0d want 2", lat); end
      n_cmp++; if (c8[31:0] !== 32'hFFFFFFFB) begin n_bad++; $display("FAIL b2b_second: got %h want fffffffb", c8[31:0]); end
      n_cmp++; if (of8 !== 16'h0) begin n_bad++; $display("FAIL b2b_ouflow: got %h want 0", of8); end
      step();
   endtask

   initial begin
      rst_n   = 1'b0;
      start8  = 1'b0; dn8 = 2'd0; dk8 = 2'd0; dm8 = 2'd0; a8 = '0; b8 = '0;
      start16 = 1'b0; dn16 = 2'd0; dk16 = 2'd0; dm16 = 2'd0; a16 = '0; b16 = '0;
      test_reset();
      test_identity();
      test_rectangular();
      test_signed();
      test_overflow();
      test_ignore_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
